load_store_unit: RTL and testbench

Bus initiator that turns core load/store requests (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide accesses on the memory interface bus (`we`/`addr`/`wd`/`rd`). It sits between the core datapath and the memory interface, which decodes ROM/RAM regions.

Per request, the block:
- aligns addresses to words;
- extracts and sign/zero-extends sub-word load data;
- performs read-modify-write for SB/SH;
- returns a single-cycle response.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned accesses fault instead of truncating).
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bytes are always aligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extraction/extension and SB/SH store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  sh_b, sh_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] mask_b, mask_h;

  // Half lane uses only addr[1], so odd half addresses truncate naturally.
  assign sh_b   = {addr_lo, 3'b000};
  assign sh_h   = {addr_lo[1], 4'b0000};
  assign lane_b = 8'(word >> sh_b);
  assign lane_h = 16'(word >> sh_h);
  assign mask_b = 32'h0000_00ff << sh_b;
  assign mask_h = 32'h0000_ffff << sh_h;

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   ld_data = {24'd0, lane_b};
      F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   ld_data = {16'd0, lane_h};
      F3_W:    ld_data = word;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    st_word = wdata;
    case (funct3)
      F3_B:    st_word = (word & ~mask_b) | ({24'd0, wdata[7:0]} << sh_b);
      F3_H:    st_word = (word & ~mask_h) | ({16'd0, wdata[15:0]} << sh_h);
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store bus initiator: word-aligned bus accesses with RMW for SB/SH.
// Optional build macro: LSU_MISALIGN_TRAP_EN (fault on misaligned LH/LHU/LW/SH/SW).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] LAST = 2'(RD_LAT);

  lsu_state_e  state_q, state_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt_q;
  logic [31:0] addr_q, wd_q, rdata_q;
  logic        fault_q;
  logic        accept, illegal, misal, bad, rd_last;
  logic [31:0] ld_data, st_word;

  assign accept  = req_valid && (state_q == S_IDLE);
  assign rd_last = (state_q == S_RD) && (cnt_q == LAST);

  always_comb begin
    illegal = 1'b0;
    if (req_store) illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else           illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign bad = illegal || misal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (bad)                                  state_d = S_RESP;
        else if (req_store && req_funct3 == F3_W) state_d = S_WR;
        else                                      state_d = S_RD;
      end
      S_RD:    if (rd_last) state_d = store_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Bus address/data only move on a legal accept or at the end of RD, so they hold in IDLE/RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      store_q <= 1'b0;
      f3_q    <= '0;
      alo_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      store_q <= req_store;
      f3_q    <= req_funct3;
      alo_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
      cnt_q   <= '0;
      fault_q <= bad;
      rdata_q <= '0;
      if (!bad) begin
        addr_q <= {req_addr[31:2], 2'b00};
        if (req_store && req_funct3 == F3_W) wd_q <= req_wdata;
      end
    end else if (state_q == S_RD) begin
      cnt_q <= cnt_q + 2'd1;
      if (rd_last) begin
        if (store_q) wd_q    <= st_word;
        else         rdata_q <= ld_data;
      end
    end
  end

  lsu_align u_align (
    .funct3  (f3_q),
    .addr_lo (alo_q),
    .word    (mem_rd),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign mem_we     = (state_q == S_WR);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign mem_addr   = addr_q;
  assign mem_wd     = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus randomized ops vs a byte-level model.
module tb_load_store_unit;

  localparam int RD_LAT = 1;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  load_store_unit #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus memory: 256 words, read data follows the address after RD_LAT cycles.
  logic [31:0] bus_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] ad1 = '0, ad2 = '0, ad3 = '0, rsel;

  always @(posedge clk) begin
    if (mem_we)     bus_mem[mem_addr[9:2]] <= mem_wd;
    else if (bd_we) bus_mem[bd_idx] <= bd_data;
    ad1 <= mem_addr; ad2 <= ad1; ad3 <= ad2;
  end
  always_comb begin
    case (RD_LAT)
      0:       rsel = mem_addr;
      1:       rsel = ad1;
      2:       rsel = ad2;
      default: rsel = ad3;
    endcase
    mem_rd = bus_mem[rsel[9:2]];
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal, mis;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
    return !legal || (TRAP && mis);
  endfunction

  function automatic int m_lat(input bit st, input logic [2:0] f3, input bit flt);
    if (flt) return 1;
    if (st && f3 == 3'd2) return 2;
    if (st) return RD_LAT + 3;
    return RD_LAT + 2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [7:0] b [4];
    int o;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    o = int'(a % 4);
    case (f3)
      3'd0: return {{24{b[o][7]}}, b[o]};
      3'd4: return {24'd0, b[o]};
      3'd1: begin o = (o / 2) * 2; return {{16{b[o+1][7]}}, b[o+1], b[o]}; end
      3'd5: begin o = (o / 2) * 2; return {16'd0, b[o+1], b[o]}; end
      3'd2: return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] old, input logic [31:0] wd);
    logic [7:0] b [4];
    int o;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    o = int'(a % 4);
    if (f3 == 3'd2) return wd;
    if (f3 == 3'd0) b[o] = wd[7:0];
    else begin o = (o / 2) * 2; b[o] = wd[7:0]; b[o+1] = wd[15:8]; end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // ---------------- drivers ----------------
  int          o_lat, o_nwe, o_acc, o_resp;
  logic [31:0] o_rdata, o_waddr, o_wdat, o_pre, o_post;
  logic        o_fault;

  task automatic poke(input logic [7:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_data = d; ref_mem[idx] = d;
    @(posedge clk); #1 bd_we = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where resp_valid is seen.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int g;
    o_lat = -1; o_rdata = '0; o_fault = 1'b0; o_nwe = 0; o_waddr = '0; o_wdat = '0;
    o_acc = -1; o_resp = -1; o_post = '0;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    o_pre = mem_addr;
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1 req_valid = 1'b0; o_acc = cyc;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_we) begin o_nwe++; o_waddr = mem_addr; o_wdat = mem_wd; end
      if (resp_valid) begin
        o_lat = k; o_rdata = resp_rdata; o_fault = resp_fault; o_post = mem_addr; o_resp = cyc;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp += 7;
    if (req_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    if (resp_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    if (resp_fault !== 1'b0)  begin n_bad++; $display("FAIL rst_fault: got %b want 0", resp_fault); end
    if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    if (mem_we !== 1'b0)      begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    if (mem_addr !== 32'd0)   begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    if (mem_wd !== 32'd0)     begin n_bad++; $display("FAIL rst_wd: got %h want 0", mem_wd); end
  endtask

  task automatic test_plan_loads();
    logic [2:0]  f3s [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] as  [5] = '{32'h0010_0004, 32'h0010_0007, 32'h0010_0007, 32'h0010_0006, 32'h0010_0004};
    logic [31:0] ex  [5] = '{32'h8765_4321, 32'hffff_ff87, 32'h0000_0087, 32'hffff_8765, 32'h0000_4321};
    poke(8'd1, 32'h8765_4321);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], as[i], 32'h0);
      n_cmp += 4;
      if (o_rdata !== ex[i])       begin n_bad++; $display("FAIL load%0d_data: got %h want %h", i, o_rdata, ex[i]); end
      if (o_lat !== RD_LAT + 2)    begin n_bad++; $display("FAIL load%0d_lat: got %0d want %0d", i, o_lat, RD_LAT + 2); end
      if (o_fault !== 1'b0)        begin n_bad++; $display("FAIL load%0d_fault: got %b want 0", i, o_fault); end
      if (o_nwe !== 0)             begin n_bad++; $display("FAIL load%0d_we: got %0d want 0", i, o_nwe); end
    end
  endtask

  task automatic test_sb();
    poke(8'd1, 32'h1122_3344);
    do_req(1'b1, 3'd0, 32'h0010_0005, 32'h0000_00ab);
    ref_mem[1] = 32'h1122_ab44;
    n_cmp += 4;
    if (o_nwe !== 1)                begin n_bad++; $display("FAIL sb_we: got %0d want 1", o_nwe); end
    if (o_waddr !== 32'h0010_0004)  begin n_bad++; $display("FAIL sb_addr: got %h want 00100004", o_waddr); end
    if (o_wdat !== 32'h1122_ab44)   begin n_bad++; $display("FAIL sb_wd: got %h want 1122ab44", o_wdat); end
    if (o_lat !== RD_LAT + 3)       begin n_bad++; $display("FAIL sb_lat: got %0d want %0d", o_lat, RD_LAT + 3); end
    do_req(1'b0, 3'd2, 32'h0010_0004, 32'h0);
    n_cmp++;
    if (o_rdata !== 32'h1122_ab44)  begin n_bad++; $display("FAIL sb_readback: got %h want 1122ab44", o_rdata); end
  endtask

  task automatic test_sw();
    do_req(1'b1, 3'd2, 32'h0010_0008, 32'hdead_beef);
    ref_mem[2] = 32'hdead_beef;
    n_cmp += 4;
    if (o_nwe !== 1)                begin n_bad++; $display("FAIL sw_we: got %0d want 1", o_nwe); end
    if (o_waddr !== 32'h0010_0008)  begin n_bad++; $display("FAIL sw_addr: got %h want 00100008", o_waddr); end
    if (o_lat !== 2)                begin n_bad++; $display("FAIL sw_lat: got %0d want 2", o_lat); end
    if (o_rdata !== 32'd0)          begin n_bad++; $display("FAIL sw_rdata: got %h want 0", o_rdata); end
    do_req(1'b0, 3'd2, 32'h0010_0008, 32'h0);
    n_cmp++;
    if (o_rdata !== 32'hdead_beef)  begin n_bad++; $display("FAIL sw_readback: got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_misalign_illegal();
    logic [31:0] ea, er;
    int          el;
    poke(8'd0, 32'h0bad_f00d);
    do_req(1'b0, 3'd2, 32'h0010_0008, 32'h0);   // park mem_addr elsewhere first
    do_req(1'b0, 3'd2, 32'h0010_0002, 32'h0);
    ea = TRAP ? o_pre : 32'h0010_0000;
    er = TRAP ? 32'd0 : 32'h0bad_f00d;
    el = TRAP ? 1 : RD_LAT + 2;
    n_cmp += 4;
    if (o_fault !== TRAP) begin n_bad++; $display("FAIL mis_fault: got %b want %b", o_fault, TRAP); end
    if (o_post !== ea)    begin n_bad++; $display("FAIL mis_addr: got %h want %h", o_post, ea); end
    if (o_rdata !== er)   begin n_bad++; $display("FAIL mis_rdata: got %h want %h", o_rdata, er); end
    if (o_lat !== el)     begin n_bad++; $display("FAIL mis_lat: got %0d want %0d", o_lat, el); end
    do_req(1'b0, 3'd3, 32'h0010_0004, 32'h0);
    n_cmp += 4;
    if (o_fault !== 1'b1)   begin n_bad++; $display("FAIL ill_ld_fault: got %b want 1", o_fault); end
    if (o_lat !== 1)        begin n_bad++; $display("FAIL ill_ld_lat: got %0d want 1", o_lat); end
    if (o_post !== o_pre)   begin n_bad++; $display("FAIL ill_ld_addr: got %h want %h", o_post, o_pre); end
    if (o_rdata !== 32'd0)  begin n_bad++; $display("FAIL ill_ld_rdata: got %h want 0", o_rdata); end
    do_req(1'b1, 3'd4, 32'h0010_0004, 32'h1234_5678);
    n_cmp += 2;
    if (o_fault !== 1'b1)   begin n_bad++; $display("FAIL ill_st_fault: got %b want 1", o_fault); end
    if (o_nwe !== 0)        begin n_bad++; $display("FAIL ill_st_we: got %0d want 0", o_nwe); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          st, ef;
      logic [2:0]  f3;
      logic [31:0] a, wd, old, ew;
      st  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
      a   = 32'h0010_0000 + 32'($urandom_range(0, 1023));
      wd  = $urandom;
      old = ref_mem[a[9:2]];
      ef  = m_fault(st, f3, a);
      do_req(st, f3, a, wd);
      n_cmp += 4;
      if (o_fault !== ef) begin n_bad++; $display("FAIL rnd%0d_fault: got %b want %b", i, o_fault, ef); end
      if (o_lat !== m_lat(st, f3, ef)) begin n_bad++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, o_lat, m_lat(st, f3, ef)); end
      if (o_nwe !== ((st && !ef) ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_we: got %0d want %0d", i, o_nwe, (st && !ef) ? 1 : 0); end
      if (o_post !== (ef ? o_pre : {a[31:2], 2'b00})) begin n_bad++; $display("FAIL rnd%0d_addr: got %h want %h", i, o_post, ef ? o_pre : {a[31:2], 2'b00}); end
      ew = (st || ef) ? 32'd0 : m_load(f3, a, old);
      n_cmp++;
      if (o_rdata !== ew) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, o_rdata, ew); end
      if (st && !ef) begin
        ew = m_store(f3, a, old, wd);
        ref_mem[a[9:2]] = ew;
        n_cmp++;
        if (o_wdat !== ew) begin n_bad++; $display("FAIL rnd%0d_wd: got %h want %h", i, o_wdat, ew); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int r;
    do_req(1'b0, 3'd2, 32'h0010_0010, 32'h0);
    r = o_resp;
    do_req(1'b1, 3'd2, 32'h0010_0010, 32'h0f0f_0f0f);
    ref_mem[4] = 32'h0f0f_0f0f;
    n_cmp++;
    if (o_acc !== r + 2) begin n_bad++; $display("FAIL b2b_accept: got cycle %0d want %0d", o_acc, r + 2); end
    r = o_resp;
    do_req(1'b0, 3'd2, 32'h0010_0010, 32'h0);
    n_cmp += 2;
    if (o_acc !== r + 2)           begin n_bad++; $display("FAIL b2b_accept2: got cycle %0d want %0d", o_acc, r + 2); end
    if (o_rdata !== 32'h0f0f_0f0f) begin n_bad++; $display("FAIL b2b_data: got %h want 0f0f0f0f", o_rdata); end
  endtask

  task automatic test_reset_mid();
    int nv, nw;
    poke(8'd5, 32'ha5a5_5a5a);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd1; req_addr = 32'h0010_0016; req_wdata = 32'h0000_1234;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp += 4;
    if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL rmid_we: got %b want 0", mem_we); end
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", resp_valid); end
    if (req_ready !== 1'b1)  begin n_bad++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    if (mem_addr !== 32'd0)  begin n_bad++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    nv = 0; nw = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) nv++;
      if (mem_we) nw++;
    end
    n_cmp += 3;
    if (nv !== 0) begin n_bad++; $display("FAIL rmid_noresp: got %0d want 0", nv); end
    if (nw !== 0) begin n_bad++; $display("FAIL rmid_nowrite: got %0d want 0", nw); end
    if (bus_mem[5] !== ref_mem[5]) begin n_bad++; $display("FAIL rmid_mem: got %h want %h", bus_mem[5], ref_mem[5]); end
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_plan_loads();
    test_sb();
    test_sw();
    test_misalign_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
